fsb_ram_sched: RTL and testbench

- Schedules the shared RAM array among three requesters: CPU bus cycles, video fetch and sound fetch.
- Generates the wait states for CPU cycles to ROM and I/O.
- Produces the Ready and IACS inputs consumed by the front-side bus DTACK/VPA logic.
- Sits between the address decoder and the FSB block; runs entirely on FCLK.

---
 rtl/fsb_ram_sched_if.sv | 29 ++
 rtl/fsb_ram_sched.sv | 194 +++++++++++++++++++
 tb/tb_fsb_ram_sched.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsb_ram_sched_if.sv
// Bus-side signal bundle for the RAM scheduler: CPU cycle status and decode
// from the FSB/address decoder, fetch strobes, and the scheduler's outputs.
interface fsb_ram_sched_if;
    logic       CACT;
    logic       AINACT;
    logic       RAMCS;
    logic       ROMCS;
    logic       IOCS;
    logic       VidReq;
    logic       SndReq;
    logic       Ready;
    logic       IACS;
    logic [1:0] Owner;
    logic       nRAS;
    logic       nCAS;
    logic       VidAck;
    logic       SndAck;
    logic       VidOvr;

    modport master (
        output CACT, AINACT, RAMCS, ROMCS, IOCS, VidReq, SndReq,
        input  Ready, IACS, Owner, nRAS, nCAS, VidAck, SndAck, VidOvr
    );

    modport slave (
        input  CACT, AINACT, RAMCS, ROMCS, IOCS, VidReq, SndReq,
        output Ready, IACS, Owner, nRAS, nCAS, VidAck, SndAck, VidOvr
    );
endinterface

// File: rtl/fsb_ram_sched.sv
// Shared-RAM scheduler: arbitrates RAM slots between CPU, video and sound
// fetches, and generates ROM/I-O wait states and the Ready/IACS pair for
// the FSB DTACK/VPA logic. The ROM/I-O wait path runs beside the RAM slot
// machine so a CPU ROM or I-O cycle never waits for a video/sound slot.
module fsb_ram_sched #(
    parameter int RAM_CYC     = 3,
    parameter int ROM_WS      = 2,
    parameter int IO_WS       = 4,
    parameter int CPU_MAXWAIT = 6
) (
    input  logic           FCLK,
    input  logic           nRES,
    fsb_ram_sched_if.slave bus
);
    typedef enum logic { S_IDLE, S_SLOT } slot_st_e;
    typedef enum logic { W_IDLE, W_CNT  } wait_st_e;

    localparam logic [3:0] SLOT_LD  = 4'(RAM_CYC - 1);
    localparam logic [3:0] ROM_LD   = 4'(ROM_WS);
    localparam logic [3:0] IO_LD    = 4'(IO_WS);
    localparam logic [3:0] MAXW     = 4'(CPU_MAXWAIT);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_VID  = 2'd2;
    localparam logic [1:0] OWN_SND  = 2'd3;

    slot_st_e   st_q, st_d;
    wait_st_e   ws_q, ws_d;
    logic [3:0] slot_cnt_q, slot_cnt_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] cpu_wait_q, cpu_wait_d;
    logic [1:0] owner_q, owner_d;
    logic       nras_q, nras_d, ncas_q, ncas_d;
    logic       vid_ack_q, vid_ack_d, snd_ack_q, snd_ack_d;
    logic       vid_pend_q, vid_pend_d, snd_pend_q, snd_pend_d;
    logic       vid_ovr_q, vid_ovr_d;
    logic       cpu_done_q, cpu_done_d;
    logic       ready_q, ready_d, iacs_q, iacs_d;

    logic cpu_pend, wc_start, cpu_grant;
    logic slot_rdy, wc_rdy, iacs_load, vid_clr, snd_clr;

    // A CPU RAM cycle needs a slot until Ready is given for it; a ROM/I-O
    // cycle starts the wait path unless RAM is also selected (RAM wins).
    assign cpu_pend = bus.CACT & bus.RAMCS & ~ready_q & ~cpu_done_q;
    assign wc_start = bus.CACT & (bus.ROMCS | bus.IOCS) & ~bus.RAMCS
                    & ~ready_q & ~cpu_done_q;

    // RAM slot machine: arbitration in IDLE, strobe sequencing in SLOT.
    always_comb begin
        st_d       = st_q;
        slot_cnt_d = slot_cnt_q;
        owner_d    = owner_q;
        nras_d     = nras_q;
        ncas_d     = ncas_q;
        vid_ack_d  = 1'b0;
        snd_ack_d  = 1'b0;
        vid_clr    = 1'b0;
        snd_clr    = 1'b0;
        slot_rdy   = 1'b0;
        cpu_grant  = 1'b0;
        case (st_q)
            S_IDLE: begin
                if (cpu_pend && (cpu_wait_q >= MAXW)) owner_d = OWN_CPU;
                else if (vid_pend_q)                  owner_d = OWN_VID;
                else if (snd_pend_q)                  owner_d = OWN_SND;
                else if (cpu_pend)                    owner_d = OWN_CPU;
                else                                  owner_d = OWN_NONE;
                if (owner_d != OWN_NONE) begin
                    st_d       = S_SLOT;
                    slot_cnt_d = SLOT_LD;
                    nras_d     = 1'b0;
                    ncas_d     = 1'b1;
                end
                cpu_grant = (owner_d == OWN_CPU);
            end
            S_SLOT: begin
                if (slot_cnt_q == 4'd0) begin
                    st_d    = S_IDLE;
                    nras_d  = 1'b1;
                    ncas_d  = 1'b1;
                    owner_d = OWN_NONE;
                    case (owner_q)
                        OWN_CPU: slot_rdy = 1'b1;
                        OWN_VID: begin vid_ack_d = 1'b1; vid_clr = 1'b1; end
                        OWN_SND: begin snd_ack_d = 1'b1; snd_clr = 1'b1; end
                        default: ;
                    endcase
                end else begin
                    slot_cnt_d = slot_cnt_q - 4'd1;
                    ncas_d     = 1'b0;
                end
            end
            default: st_d = S_IDLE;
        endcase
    end

    // ROM/I-O wait-state path; a zero load gives Ready on the load edge.
    always_comb begin
        ws_d       = ws_q;
        wait_cnt_d = wait_cnt_q;
        wc_rdy     = 1'b0;
        iacs_load  = 1'b0;
        case (ws_q)
            W_IDLE: begin
                if (wc_start) begin
                    iacs_load  = 1'b1;
                    wait_cnt_d = bus.ROMCS ? ROM_LD : IO_LD;
                    if (wait_cnt_d == 4'd0) wc_rdy = 1'b1;
                    else                    ws_d   = W_CNT;
                end
            end
            W_CNT: begin
                if (wait_cnt_q <= 4'd1) begin
                    wc_rdy = 1'b1;
                    ws_d   = W_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            default: ws_d = W_IDLE;
        endcase
    end

    // Ready/IACS/pend flags; AINACT ends the CPU cycle and overrides any
    // Ready that would have been raised on the same edge.
    always_comb begin
        ready_d    = bus.AINACT ? 1'b0 : (ready_q | slot_rdy | wc_rdy);
        cpu_done_d = bus.AINACT ? 1'b0 : (cpu_done_q | slot_rdy | wc_rdy);
        iacs_d     = bus.AINACT ? 1'b0 : (iacs_load ? bus.IOCS : iacs_q);
        vid_pend_d = (vid_pend_q & ~vid_clr) | bus.VidReq;
        vid_ovr_d  = vid_ovr_q | (bus.VidReq & vid_pend_q & ~vid_clr);
        snd_pend_d = (snd_pend_q & ~snd_clr) | bus.SndReq;
        cpu_wait_d = cpu_wait_q;
        if (cpu_grant || !cpu_pend)
            cpu_wait_d = 4'd0;
        else if (owner_q != OWN_CPU && cpu_wait_q != 4'hF)
            cpu_wait_d = cpu_wait_q + 4'd1;
    end

    // State registers; reset aborts a slot and releases the strobes at once.
    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            st_q       <= S_IDLE;
            ws_q       <= W_IDLE;
            slot_cnt_q <= 4'd0;
            wait_cnt_q <= 4'd0;
            cpu_wait_q <= 4'd0;
            owner_q    <= OWN_NONE;
            nras_q     <= 1'b1;
            ncas_q     <= 1'b1;
            vid_ack_q  <= 1'b0;
            snd_ack_q  <= 1'b0;
            vid_pend_q <= 1'b0;
            snd_pend_q <= 1'b0;
            vid_ovr_q  <= 1'b0;
            cpu_done_q <= 1'b0;
            ready_q    <= 1'b0;
            iacs_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            ws_q       <= ws_d;
            slot_cnt_q <= slot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            cpu_wait_q <= cpu_wait_d;
            owner_q    <= owner_d;
            nras_q     <= nras_d;
            ncas_q     <= ncas_d;
            vid_ack_q  <= vid_ack_d;
            snd_ack_q  <= snd_ack_d;
            vid_pend_q <= vid_pend_d;
            snd_pend_q <= snd_pend_d;
            vid_ovr_q  <= vid_ovr_d;
            cpu_done_q <= cpu_done_d;
            ready_q    <= ready_d;
            iacs_q     <= iacs_d;
        end
    end

    // Slot length only makes sense for 2..7 cycles.
    always @(posedge FCLK) begin
        assert (RAM_CYC >= 2 && RAM_CYC <= 7)
            else $error("fsb_ram_sched: RAM_CYC=%0d unsupported", RAM_CYC);
    end

    assign bus.Ready  = ready_q;
    assign bus.IACS   = iacs_q;
    assign bus.Owner  = owner_q;
    assign bus.nRAS   = nras_q;
    assign bus.nCAS   = ncas_q;
    assign bus.VidAck = vid_ack_q;
    assign bus.SndAck = snd_ack_q;
    assign bus.VidOvr = vid_ovr_q;
endmodule

// File: tb/tb_fsb_ram_sched.sv
// Testbench for fsb_ram_sched: directed vector table, hand-written corner
// sequences and a randomized run, all tracked by a timestamp-based model.
module tb_fsb_ram_sched;
    localparam int RC  = 3;
    localparam int RWS = 0;
    localparam int IWS = 4;
    localparam int MW  = 6;

    logic FCLK = 1'b0;
    logic nRES = 1'b0;
    fsb_ram_sched_if bus();

    fsb_ram_sched #(.RAM_CYC(RC), .ROM_WS(RWS), .IO_WS(IWS), .CPU_MAXWAIT(MW))
        dut (.FCLK(FCLK), .nRES(nRES), .bus(bus));

    always #5 FCLK = ~FCLK;

    int checks = 0;
    int failures = 0;

    // Reference model state: slots tracked by grant timestamp, waits by due edge
    int m_k = 0;
    int m_owner, m_start, m_wait, m_due;
    bit m_vpend, m_spend, m_done, m_ready, m_iacs, m_ovr, m_vack, m_sack, m_wbusy;

    typedef struct {
        logic [6:0] in;   // {CACT, AINACT, RAMCS, ROMCS, IOCS, VidReq, SndReq}
        logic [8:0] exp;  // {Ready, IACS, Owner[1:0], nRAS, nCAS, VidAck, SndAck, VidOvr}
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mkv(logic [6:0] i, logic [8:0] e);
        vec_t v;
        v.in = i;
        v.exp = e;
        return v;
    endfunction

    function automatic logic [8:0] outs();
        return {bus.Ready, bus.IACS, bus.Owner, bus.nRAS, bus.nCAS,
                bus.VidAck, bus.SndAck, bus.VidOvr};
    endfunction

    function automatic logic [8:0] mexp();
        logic ncas;
        ncas = !(m_owner != 0 && (m_k - m_start) >= 1);
        return {m_ready, m_iacs, 2'(m_owner), (m_owner == 0), ncas,
                m_vack, m_sack, m_ovr};
    endfunction

    task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic set_in(logic [6:0] i);
        {bus.CACT, bus.AINACT, bus.RAMCS, bus.ROMCS, bus.IOCS, bus.VidReq, bus.SndReq} = i;
    endtask

    task automatic model_reset();
        m_owner = 0; m_start = 0; m_wait = 0; m_due = 0;
        m_vpend = 0; m_spend = 0; m_done = 0; m_ready = 0; m_iacs = 0;
        m_ovr = 0; m_vack = 0; m_sack = 0; m_wbusy = 0;
    endtask

    task automatic model_update();
        bit cpu_pend, wc_start, set_rdy, vclr, sclr, gcpu, load;
        int n_owner, n_wait, ws;
        m_k++;
        cpu_pend = bus.CACT && bus.RAMCS && !m_ready && !m_done;
        wc_start = bus.CACT && (bus.ROMCS || bus.IOCS) && !bus.RAMCS && !m_ready && !m_done;
        set_rdy = 0; vclr = 0; sclr = 0; gcpu = 0; load = 0;
        n_owner = m_owner;
        m_vack = 0; m_sack = 0;
        if (m_owner != 0) begin
            if (m_k - 1 - m_start == RC - 1) begin
                if (m_owner == 1) set_rdy = 1;
                if (m_owner == 2) begin m_vack = 1; vclr = 1; end
                if (m_owner == 3) begin m_sack = 1; sclr = 1; end
                n_owner = 0;
            end
        end else begin
            if (cpu_pend && m_wait >= MW) n_owner = 1;
            else if (m_vpend)             n_owner = 2;
            else if (m_spend)             n_owner = 3;
            else if (cpu_pend)            n_owner = 1;
            if (n_owner != 0) m_start = m_k;
            gcpu = (n_owner == 1);
        end
        n_wait = m_wait;
        if (gcpu || !cpu_pend) n_wait = 0;
        else if (m_owner != 1) n_wait = (m_wait >= 15) ? 15 : m_wait + 1;
        if (m_wbusy) begin
            if (m_k == m_due) begin set_rdy = 1; m_wbusy = 0; end
        end else if (wc_start) begin
            load = 1;
            ws = bus.ROMCS ? RWS : IWS;
            if (ws == 0) set_rdy = 1;
            else begin m_wbusy = 1; m_due = m_k + ws; end
        end
        if (bus.AINACT) begin
            m_ready = 0; m_done = 0; m_iacs = 0;
        end else begin
            if (set_rdy) begin m_ready = 1; m_done = 1; end
            if (load) m_iacs = bus.IOCS;
        end
        if (bus.VidReq && m_vpend && !vclr) m_ovr = 1;
        m_vpend = (m_vpend && !vclr) || bus.VidReq;
        m_spend = (m_spend && !sclr) || bus.SndReq;
        m_owner = n_owner;
        m_wait = n_wait;
    endtask

    task automatic step();
        @(posedge FCLK);
        model_update();
        #1;
        chk($sformatf("model@%0d", m_k), outs(), mexp());
    endtask

    task automatic apply_reset();
        nRES = 1'b0;
        set_in(7'b0);
        repeat (2) @(posedge FCLK);
        #1;
        chk("reset_state", outs(), 9'b0_0_00_1_1_000);
        nRES = 1'b1;
        model_reset();
    endtask

    initial begin
        int gp, rdy_k, first_vack, first_cpu, rise_k, grant_k, vacks, cs, sel, age;
        bit cpu_seen, gone2;
        logic [6:0] iv;

        // Directed table: CPU RAM, I/O, ROM, RAM+ROM, no-select, AINACT at slot end, sound
        tv.push_back(mkv(7'b1010000, 9'b0_0_01_0_1_000));
        tv.push_back(mkv(7'b1010000, 9'b0_0_01_0_0_000));
        tv.push_back(mkv(7'b1010000, 9'b0_0_01_0_0_000));
        tv.push_back(mkv(7'b1010000, 9'b1_0_00_1_1_000));
        tv.push_back(mkv(7'b1010000, 9'b1_0_00_1_1_000));
        tv.push_back(mkv(7'b0100000, 9'b0_0_00_1_1_000));
        tv.push_back(mkv(7'b0000000, 9'b0_0_00_1_1_000));
        tv.push_back(mkv(7'b1000100, 9'b0_1_00_1_1_000));
        tv.push_back(mkv(7'b1000100, 9'b0_1_00_1_1_000));
        tv.push_back(mkv(7'b1000100, 9'b0_1_00_1_1_000));
        tv.push_back(mkv(7'b1000100, 9'b0_1_00_1_1_000));
        tv.push_back(mkv(7'b1000100, 9'b1_1_00_1_1_000));
        tv.push_back(mkv(7'b0100000, 9'b0_0_00_1_1_000));
        tv.push_back(mkv(7'b1001000, 9'b1_0_00_1_1_000));
        tv.push_back(mkv(7'b0100000, 9'b0_0_00_1_1_000));
        tv.push_back(mkv(7'b1011000, 9'b0_0_01_0_1_000));
        tv.push_back(mkv(7'b1011000, 9'b0_0_01_0_0_000));
        tv.push_back(mkv(7'b1011000, 9'b0_0_01_0_0_000));
        tv.push_back(mkv(7'b1011000, 9'b1_0_00_1_1_000));
        tv.push_back(mkv(7'b0100000, 9'b0_0_00_1_1_000));
        tv.push_back(mkv(7'b1000000, 9'b0_0_00_1_1_000));
        tv.push_back(mkv(7'b1000000, 9'b0_0_00_1_1_000));
        tv.push_back(mkv(7'b0100000, 9'b0_0_00_1_1_000));
        tv.push_back(mkv(7'b1010000, 9'b0_0_01_0_1_000));
        tv.push_back(mkv(7'b1010000, 9'b0_0_01_0_0_000));
        tv.push_back(mkv(7'b1010000, 9'b0_0_01_0_0_000));
        tv.push_back(mkv(7'b0110000, 9'b0_0_00_1_1_000));
        tv.push_back(mkv(7'b0000000, 9'b0_0_00_1_1_000));
        tv.push_back(mkv(7'b0000001, 9'b0_0_00_1_1_000));
        tv.push_back(mkv(7'b0000000, 9'b0_0_11_0_1_000));
        tv.push_back(mkv(7'b0000000, 9'b0_0_11_0_0_000));
        tv.push_back(mkv(7'b0000000, 9'b0_0_11_0_0_000));
        tv.push_back(mkv(7'b0000000, 9'b0_0_00_1_1_010));
        tv.push_back(mkv(7'b0000000, 9'b0_0_00_1_1_000));

        set_in(7'b0);
        model_reset();
        apply_reset();
        foreach (tv[i]) begin
            set_in(tv[i].in);
            step();
            chk($sformatf("tbl[%0d]", i), outs(), tv[i].exp);
        end

        // Reset in the middle of a video slot
        apply_reset();
        set_in(7'b0000010); step();
        set_in(7'b0000000); step();
        step();
        chk_int("vid_slot_live_owner", int'(bus.Owner), 2);
        #2 nRES = 1'b0;
        #1;
        chk_int("rst_async_nras", int'(bus.nRAS), 1);
        chk_int("rst_async_owner", int'(bus.Owner), 0);
        @(posedge FCLK);
        #1 nRES = 1'b1;
        model_reset();
        vacks = 0; gone2 = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.VidAck) vacks++;
            if (bus.Owner == 2'd2) gone2 = 1;
        end
        chk_int("rst_no_vidack", vacks, 0);
        chk_int("rst_vidpend_cleared", int'(gone2), 0);

        // Video and CPU both pending: video slot first, then the CPU slot
        apply_reset();
        set_in(7'b0000010); step();
        set_in(7'b1010000); step();
        gp = m_k;
        chk_int("vid_granted_first", int'(bus.Owner), 2);
        rdy_k = -1; first_vack = -1; first_cpu = -1;
        for (int i = 0; i < 20 && rdy_k < 0; i++) begin
            step();
            if (bus.VidAck && first_vack < 0) first_vack = m_k;
            if (bus.Owner == 2'd1 && first_cpu < 0) first_cpu = m_k;
            if (bus.Ready) rdy_k = m_k;
        end
        chk_int("vidack_before_cpu", int'(first_vack >= 0 && first_vack < first_cpu), 1);
        chk_int("cpu_ready_latency", rdy_k - gp, 2 * RC + 1);
        set_in(7'b0100000); step();
        set_in(7'b0000000); step();

        // Steady video and sound traffic; CPU must still get a slot
        apply_reset();
        rise_k = -1; grant_k = -1; cpu_seen = 0;
        for (int i = 0; i < 40; i++) begin
            iv = 7'b0;
            if (i % 3 == 0) iv[1] = 1'b1;
            if (i % 3 == 1) iv[0] = 1'b1;
            if (i >= 1 && !cpu_seen) iv[6:4] = 3'b101;
            if (cpu_seen && m_ready) begin iv[6:4] = 3'b010; cpu_seen = 0; grant_k = grant_k; end
            set_in(iv);
            if (rise_k < 0 && iv[6]) rise_k = m_k + 1;
            step();
            if (bus.Owner == 2'd1 && grant_k < 0) grant_k = m_k;
            if (grant_k >= 0 && !m_ready && iv[6]) cpu_seen = 1;
        end
        chk_int("cpu_maxwait_bound", int'(grant_k >= 0 && (grant_k - rise_k) <= MW + RC), 1);
        set_in(7'b0100000); step();
        set_in(7'b0000000); step();

        // Two VidReq strobes while a sound slot runs
        apply_reset();
        set_in(7'b0000001); step();
        set_in(7'b0000000); step();
        chk_int("snd_slot_owner", int'(bus.Owner), 3);
        set_in(7'b0000010); step();
        set_in(7'b0000010); step();
        chk_int("vidovr_set", int'(bus.VidOvr), 1);
        set_in(7'b0000000);
        vacks = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.VidAck) vacks++;
        end
        chk_int("one_video_slot", vacks, 1);
        chk_int("vidovr_sticky", int'(bus.VidOvr), 1);

        // Randomized traffic against the model
        apply_reset();
        cs = 0; sel = 0; age = 0;
        for (int i = 0; i < 3000; i++) begin
            iv = 7'b0;
            iv[1] = ($urandom_range(0, 5) == 0);
            iv[0] = ($urandom_range(0, 7) == 0);
            if (cs == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    cs = 1; age = 0;
                    sel = $urandom_range(0, 4);
                end
            end else begin
                age++;
                if ((m_ready || (sel == 0 && age > 3) || age > 200) && $urandom_range(0, 2) == 0) begin
                    cs = 0;
                    iv[5] = 1'b1;
                end
            end
            if (cs == 1) begin
                iv[6] = 1'b1;
                case (sel)
                    1: iv[4] = 1'b1;
                    2: iv[3] = 1'b1;
                    3: iv[2] = 1'b1;
                    4: begin iv[4] = 1'b1; iv[2] = 1'b1; end
                    default: ;
                endcase
            end
            set_in(iv);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
